// File: rtl/cpu.sv
// ---------------------------------------------------------------------------
// cpu -- 5-stage pipelined 32-bit MIPS-subset processor (IF/ID/EX/MEM/WB).
//
// Ports (top level):
//   clk_i    in  1  single clock, all state changes on the rising edge
//   start_i  in  1  asynchronous active-low reset (0 = held in reset, 1 = run)
//
// Supported instructions: add, sub, and, or, mul (R-type), addi, lw, sw, beq, j.
// Any other encoding flows through the pipe without side effects.
// Branches and jumps resolve in ID with a single-cycle flush of IF/ID.
// Load-use and branch-operand hazards stall one cycle; all other RAW hazards
// are forwarded (EX/MEM over MEM/WB over the register file).
// Memories and the register file are not reset; the program and data are
// loaded from outside before start_i is released.
// ---------------------------------------------------------------------------

package cpu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_MUL = 6'b011000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_MUL = 3'd4
    } alu_sel_e;

    typedef struct packed {
        alu_sel_e alu_sel;
        logic     reg_dst;     // destination is rd (R-type) rather than rt
        logic     alu_src;     // ALU operand B is the sign-extended immediate
        logic     mem_write;
        logic     mem_to_reg;  // write-back value comes from data memory (lw)
        logic     reg_write;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  dst;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  dst;
    } mem_wb_t;
endpackage

// Program counter; holds while a stall is requested.
module cpu_pc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_o
);
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_o <= '0;
        else if (!stall)
            pc_o <= pc_i;
    end
endmodule

// 256-word instruction memory, combinational read. The write port is a
// program-load hook and is tied off inside cpu.
module cpu_imem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] instr
);
    logic [31:0] memory [0:255];
    logic        unused;

    // NOTE: storage arrays carry no reset; only control state is reset.
    always_ff @(posedge clk) begin
        if (we)
            memory[waddr] <= wdata;
    end

    assign instr  = memory[pc[9:2]];
    assign unused = &{1'b0, pc[31:10], pc[1:0]};
endmodule

// 32x32 register file, two read ports with write-through, r0 hard-wired to 0.
module cpu_regfile (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0)
            register[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : register[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : register[ra2];
endmodule

// Main decoder. Control_o is forced to zero while a stall inserts a bubble.
module cpu_control
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       stall,
    output ctrl_t      Control_o,
    output logic       Branch_o,
    output logic       Jump_o
);
    ctrl_t ctrl;

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        ctrl     = '0;
        Branch_o = 1'b0;
        Jump_o   = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (funct)
                    F_ADD:   ctrl.alu_sel = ALU_ADD;
                    F_SUB:   ctrl.alu_sel = ALU_SUB;
                    F_AND:   ctrl.alu_sel = ALU_AND;
                    F_OR:    ctrl.alu_sel = ALU_OR;
                    F_MUL:   ctrl.alu_sel = ALU_MUL;
                    default: ctrl.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_BEQ:  Branch_o = 1'b1;
            OP_J:    Jump_o   = 1'b1;
            default: ;
        endcase
    end

    // Kept outside the decode block: stall depends on Branch_o.
    assign Control_o = stall ? '0 : ctrl;
endmodule

// Stall request: load-use on any ID consumer, or a beq whose operand is still
// being computed in EX (its value is not available until EX/MEM).
module cpu_hazard (
    input  logic       ex_mem_to_reg,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_dst,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       branch,
    output logic       HD_o
);
    logic hit;

    assign hit  = (ex_dst != 5'd0) && (ex_dst == rs || ex_dst == rt);
    assign HD_o = hit && (ex_mem_to_reg || (branch && ex_reg_write));
endmodule

// IF/ID register: flush wins over hold.
module cpu_if_id (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush_i,
    input  logic [31:0] pc4_next,
    input  logic [31:0] instr_next,
    output logic [31:0] pc4,
    output logic [31:0] instr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4   <= '0;
            instr <= '0;
        end else if (flush_i) begin
            pc4   <= '0;
            instr <= '0;
        end else if (!stall) begin
            pc4   <= pc4_next;
            instr <= instr_next;
        end
    end
endmodule

// 32-byte little-endian data memory; word access, wrapping inside 32 bytes.
module cpu_dmem (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [7:0] memory [0:31];
    logic [4:0] a0, a1, a2, a3;
    logic       unused;

    assign a0 = addr[4:0];
    assign a1 = a0 + 5'd1;
    assign a2 = a0 + 5'd2;
    assign a3 = a0 + 5'd3;

    always_ff @(posedge clk) begin
        if (we) begin
            memory[a0] <= wdata[7:0];
            memory[a1] <= wdata[15:8];
            memory[a2] <= wdata[23:16];
            memory[a3] <= wdata[31:24];
        end
    end

    assign rdata  = {memory[a3], memory[a2], memory[a1], memory[a0]};
    assign unused = &{1'b0, addr[31:5]};
endmodule

module cpu
    import cpu_pkg::*;
(
    input logic clk_i,
    input logic start_i
);
    logic [31:0] f_pc, f_pc4, f_instr, pc_next;
    logic [31:0] d_pc4, d_instr, d_imm, d_rs_val, d_rt_val, d_a, d_b, d_target;
    logic [4:0]  d_rs, d_rt, d_rd;
    ctrl_t       d_ctrl;
    logic        d_branch, d_jump, hd, redirect;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;
    logic [31:0] e_a, e_b, e_opb, e_alu;
    logic [31:0] m_rdata, m_val, w_data;
    logic        unused;

    // ---------------- IF ----------------
    cpu_pc PC (.clk(clk_i), .rst_n(start_i), .stall(hd), .pc_i(pc_next), .pc_o(f_pc));

    cpu_imem Instruction_Memory (
        .clk(clk_i), .we(1'b0), .waddr(8'd0), .wdata(32'd0),
        .pc(f_pc), .instr(f_instr)
    );

    assign f_pc4   = f_pc + 32'd4;
    assign pc_next = redirect ? d_target : f_pc4;

    cpu_if_id Stage1 (
        .clk(clk_i), .rst_n(start_i), .stall(hd), .flush_i(redirect),
        .pc4_next(f_pc4), .instr_next(f_instr), .pc4(d_pc4), .instr(d_instr)
    );

    // ---------------- ID ----------------
    assign d_rs  = d_instr[25:21];
    assign d_rt  = d_instr[20:16];
    assign d_rd  = d_instr[15:11];
    assign d_imm = {{16{d_instr[15]}}, d_instr[15:0]};

    cpu_control Control (
        .op(d_instr[31:26]), .funct(d_instr[5:0]), .stall(hd),
        .Control_o(d_ctrl), .Branch_o(d_branch), .Jump_o(d_jump)
    );

    cpu_regfile Registers (
        .clk(clk_i), .ra1(d_rs), .ra2(d_rt), .rd1(d_rs_val), .rd2(d_rt_val),
        .we(mem_wb.reg_write), .wa(mem_wb.dst), .wd(w_data)
    );

    cpu_hazard HD_Unit (
        .ex_mem_to_reg(id_ex.ctrl.mem_to_reg), .ex_reg_write(id_ex.ctrl.reg_write),
        .ex_dst(id_ex.dst), .rs(d_rs), .rt(d_rt), .branch(d_branch), .HD_o(hd)
    );

    // Branch comparator operands: an EX/MEM producer is forwarded here, a
    // MEM/WB producer arrives through the register-file write-through, and an
    // ID/EX producer has already caused a stall.
    always_comb begin
        d_a = d_rs_val;
        d_b = d_rt_val;
        if (ex_mem.reg_write && ex_mem.dst != 5'd0 && ex_mem.dst == d_rs)
            d_a = m_val;
        if (ex_mem.reg_write && ex_mem.dst != 5'd0 && ex_mem.dst == d_rt)
            d_b = m_val;
    end

    assign redirect = !hd && (d_jump || (d_branch && d_a == d_b));
    assign d_target = d_jump ? {d_pc4[31:28], d_instr[25:0], 2'b00}
                             : d_pc4 + {d_imm[29:0], 2'b00};

    // ---------------- EX ----------------
    always_comb begin
        e_a = id_ex.a;
        e_b = id_ex.b;
        if (ex_mem.reg_write && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rs)
            e_a = m_val;
        else if (mem_wb.reg_write && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rs)
            e_a = w_data;
        if (ex_mem.reg_write && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rt)
            e_b = m_val;
        else if (mem_wb.reg_write && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rt)
            e_b = w_data;
    end

    assign e_opb = id_ex.ctrl.alu_src ? id_ex.imm : e_b;

    always_comb begin
        e_alu = '0;
        case (id_ex.ctrl.alu_sel)
            ALU_ADD: e_alu = e_a + e_opb;
            ALU_SUB: e_alu = e_a - e_opb;
            ALU_AND: e_alu = e_a & e_opb;
            ALU_OR:  e_alu = e_a | e_opb;
            ALU_MUL: e_alu = e_a * e_opb;
            default: e_alu = '0;
        endcase
    end

    // ---------------- MEM / WB ----------------
    cpu_dmem Data_Memory (
        .clk(clk_i), .we(ex_mem.mem_write), .addr(ex_mem.alu),
        .wdata(ex_mem.sdata), .rdata(m_rdata)
    );

    assign m_val  = ex_mem.mem_to_reg ? m_rdata : ex_mem.alu;
    assign w_data = mem_wb.mem_to_reg ? mem_wb.rdata : mem_wb.alu;

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex.ctrl <= d_ctrl;
            id_ex.a    <= d_rs_val;
            id_ex.b    <= d_rt_val;
            id_ex.imm  <= d_imm;
            id_ex.rs   <= d_rs;
            id_ex.rt   <= d_rt;
            id_ex.dst  <= d_ctrl.reg_dst ? d_rd : d_rt;

            ex_mem.reg_write  <= id_ex.ctrl.reg_write;
            ex_mem.mem_to_reg <= id_ex.ctrl.mem_to_reg;
            ex_mem.mem_write  <= id_ex.ctrl.mem_write;
            ex_mem.alu        <= e_alu;
            ex_mem.sdata      <= e_b;
            ex_mem.dst        <= id_ex.dst;

            mem_wb.reg_write  <= ex_mem.reg_write;
            mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
            mem_wb.alu        <= ex_mem.alu;
            mem_wb.rdata      <= m_rdata;
            mem_wb.dst        <= ex_mem.dst;
        end
    end

    assign unused = &{1'b0, d_instr[10:6], id_ex.ctrl.reg_dst};
endmodule

// File: tb/tb_cpu.sv
// ---------------------------------------------------------------------------
// tb_cpu -- directed programs for the pipelined cpu: reset/PC sequencing,
// ALU forwarding, load-use stall, stores, taken/untaken branches with an
// operand hazard, and jump. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_cpu;
    logic clk_i = 1'b0;
    logic start_i = 1'b0;
    logic cnt_clr = 1'b1;

    int   tests = 0;
    int   failures = 0;
    int   stall_cnt = 0;
    int   flush_cnt = 0;
    logic bubble_err = 1'b0;
    logic found;

    cpu dut (.clk_i(clk_i), .start_i(start_i));

    initial forever #5 clk_i = ~clk_i;

    // Event counters sampled away from the rising edge.
    always @(negedge clk_i) begin
        if (cnt_clr) begin
            stall_cnt  <= 0;
            flush_cnt  <= 0;
            bubble_err <= 1'b0;
        end else begin
            if (dut.HD_Unit.HD_o) begin
                stall_cnt <= stall_cnt + 1;
                if (dut.Control.Control_o != '0)
                    bubble_err <= 1'b1;
            end
            if (dut.Stage1.flush_i)
                flush_cnt <= flush_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Enter reset and wipe memories; caller then loads the program.
    task automatic hold_reset();
        start_i = 1'b0;
        cnt_clr = 1'b1;
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            dut.Data_Memory.memory[i] = 8'h00;
            dut.Registers.register[i] = 32'h0;
        end
    endtask

    // Called on a falling-edge boundary: release 12 ns later.
    task automatic release_reset();
        #12;
        start_i = 1'b1;
        cnt_clr = 1'b0;
    endtask

    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                           OR_ = 6'b100101, MUL = 6'b011000;
    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;

    initial begin
        // ---------------- Program 1: reset, ALU ops, forwarding ----------------
        hold_reset();
        dut.Instruction_Memory.memory[0]  = itype(ADDI, 8, 0, 16'd5);
        dut.Instruction_Memory.memory[1]  = rtype(ADD, 9, 8, 8);
        dut.Instruction_Memory.memory[2]  = rtype(SUB, 10, 9, 8);
        dut.Instruction_Memory.memory[3]  = rtype(OR_, 12, 9, 8);
        dut.Instruction_Memory.memory[4]  = rtype(AND_, 11, 12, 9);
        dut.Instruction_Memory.memory[5]  = rtype(MUL, 13, 9, 12);
        dut.Instruction_Memory.memory[6]  = itype(ADDI, 14, 0, 16'hFFFF);
        dut.Instruction_Memory.memory[7]  = rtype(ADD, 15, 14, 14);
        dut.Instruction_Memory.memory[8]  = itype(ADDI, 0, 0, 16'd9);
        dut.Instruction_Memory.memory[9]  = rtype(ADD, 16, 0, 0);
        dut.Instruction_Memory.memory[10] = itype(ADDI, 17, 0, 16'hFFFD);
        dut.Instruction_Memory.memory[11] = rtype(MUL, 18, 17, 8);
        release_reset();
        check("reset_pc", dut.PC.pc_o, 32'd0);
        @(negedge clk_i);
        check("pc_cycle1", dut.PC.pc_o, 32'd4);
        @(negedge clk_i);
        check("pc_cycle2", dut.PC.pc_o, 32'd8);
        repeat (20) @(negedge clk_i);
        check("addi_r8", dut.Registers.register[8], 32'd5);
        check("fwd_add_r9", dut.Registers.register[9], 32'd10);
        check("sub_r10", dut.Registers.register[10], 32'd5);
        check("and_r11", dut.Registers.register[11], 32'd10);
        check("or_r12", dut.Registers.register[12], 32'd15);
        check("mul_r13", dut.Registers.register[13], 32'd150);
        check("addi_neg_r14", dut.Registers.register[14], 32'hFFFF_FFFF);
        check("wrap_add_r15", dut.Registers.register[15], 32'hFFFF_FFFE);
        check("r0_unwritten", dut.Registers.register[0], 32'd0);
        check("no_fwd_from_r0", dut.Registers.register[16], 32'd0);
        check("mul_neg_r18", dut.Registers.register[18], 32'hFFFF_FFF1);
        check("p1_stalls", stall_cnt, 32'd0);
        check("p1_flushes", flush_cnt, 32'd0);

        // ---------------- Program 2: load-use, store, little-endian load ----------------
        hold_reset();
        dut.Data_Memory.memory[0]  = 8'h05;
        dut.Data_Memory.memory[4]  = 8'hFF;
        dut.Data_Memory.memory[5]  = 8'hFF;
        dut.Data_Memory.memory[6]  = 8'hFF;
        dut.Data_Memory.memory[7]  = 8'hFF;
        dut.Data_Memory.memory[8]  = 8'h78;
        dut.Data_Memory.memory[9]  = 8'h56;
        dut.Data_Memory.memory[10] = 8'h34;
        dut.Data_Memory.memory[11] = 8'h12;
        dut.Instruction_Memory.memory[0] = itype(LW, 8, 0, 16'd0);
        dut.Instruction_Memory.memory[1] = rtype(ADD, 9, 8, 8);
        dut.Instruction_Memory.memory[2] = itype(SW, 9, 0, 16'd4);
        dut.Instruction_Memory.memory[3] = itype(LW, 10, 0, 16'd4);
        dut.Instruction_Memory.memory[5] = rtype(ADD, 11, 10, 10);
        dut.Instruction_Memory.memory[6] = itype(LW, 12, 0, 16'd8);
        release_reset();
        repeat (20) @(negedge clk_i);
        check("lw_r8", dut.Registers.register[8], 32'd5);
        check("loaduse_r9", dut.Registers.register[9], 32'd10);
        check("sw_mem4", dut.Data_Memory.memory[4], 32'h0A);
        check("sw_mem5", dut.Data_Memory.memory[5], 32'h00);
        check("sw_mem6", dut.Data_Memory.memory[6], 32'h00);
        check("sw_mem7", dut.Data_Memory.memory[7], 32'h00);
        check("lw_after_sw_r10", dut.Registers.register[10], 32'd10);
        check("add_r11", dut.Registers.register[11], 32'd20);
        check("lw_le_r12", dut.Registers.register[12], 32'h1234_5678);
        check("p2_stalls", stall_cnt, 32'd1);
        check("p2_bubble_ctrl_zero", {31'd0, bubble_err}, 32'd0);
        check("p2_flushes", flush_cnt, 32'd0);

        // ---------------- Program 3: branches ----------------
        hold_reset();
        dut.Instruction_Memory.memory[0] = itype(ADDI, 8, 0, 16'd3);
        dut.Instruction_Memory.memory[1] = itype(BEQ, 0, 0, 16'd1);
        dut.Instruction_Memory.memory[2] = itype(ADDI, 10, 0, 16'd7);
        dut.Instruction_Memory.memory[3] = itype(ADDI, 11, 0, 16'd9);
        dut.Instruction_Memory.memory[4] = itype(ADDI, 12, 0, 16'd3);
        dut.Instruction_Memory.memory[5] = itype(BEQ, 8, 12, 16'd1);
        dut.Instruction_Memory.memory[6] = itype(ADDI, 13, 0, 16'd1);
        dut.Instruction_Memory.memory[7] = itype(BEQ, 11, 8, 16'd1);
        dut.Instruction_Memory.memory[8] = itype(ADDI, 14, 0, 16'd2);
        release_reset();
        repeat (20) @(negedge clk_i);
        check("beq_skip_r10", dut.Registers.register[10], 32'd0);
        check("beq_target_r11", dut.Registers.register[11], 32'd9);
        check("beq_hazard_skip_r13", dut.Registers.register[13], 32'd0);
        check("beq_untaken_r14", dut.Registers.register[14], 32'd2);
        check("p3_flushes", flush_cnt, 32'd2);
        check("p3_stalls", stall_cnt, 32'd1);

        // ---------------- Program 4: jump ----------------
        hold_reset();
        dut.Instruction_Memory.memory[0] = itype(ADDI, 8, 0, 16'd1);
        dut.Instruction_Memory.memory[1] = {6'b000010, 26'd8};
        dut.Instruction_Memory.memory[2] = itype(ADDI, 10, 0, 16'd7);
        dut.Instruction_Memory.memory[3] = itype(ADDI, 11, 0, 16'd5);
        dut.Instruction_Memory.memory[8] = itype(ADDI, 12, 0, 16'd4);
        release_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (dut.Stage1.flush_i) begin
                found = 1'b1;
                break;
            end
        end
        check("jump_flush_seen", {31'd0, found}, 32'd1);
        check("jump_ctrl", {31'd0, dut.Control.Jump_o}, 32'd1);
        @(negedge clk_i);
        check("jump_pc", dut.PC.pc_o, 32'd32);
        repeat (15) @(negedge clk_i);
        check("j_before_r8", dut.Registers.register[8], 32'd1);
        check("j_flushed_r10", dut.Registers.register[10], 32'd0);
        check("j_skipped_r11", dut.Registers.register[11], 32'd0);
        check("j_target_r12", dut.Registers.register[12], 32'd4);
        check("p4_flushes", flush_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
